// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data bits, parity and stop bits.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE} state_e;

    state_e               state_q, state_d;
    logic                 s1_q, rs_q, rs_prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 pacc_q, pacc_d;
    logic                 facc_q, facc_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 sample, tick, fall;

    // s1_q already holds next cycle's rs, so mid+1 is available at mid
    // and the majority build keeps exactly the same sample timing.
`ifdef UART_RX_MAJORITY_EN
    assign sample = (rs_prev_q & rs_q) | (rs_prev_q & s1_q) | (rs_q & s1_q);
`else
    assign sample = rs_q;
`endif

    assign fall = rs_prev_q & ~rs_q;
    assign tick = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            pacc_q    <= 1'b0;
            facc_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= rx_in;
            rs_q      <= s1_q;
            rs_prev_q <= rs_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            pacc_q    <= pacc_d;
            facc_q    <= facc_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        pacc_d  = pacc_q;
        facc_d  = facc_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        if (!rx_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (fall) begin
                        state_d = START;
                        bit_d   = '0;
                        pacc_d  = 1'b0;
                        facc_d  = 1'b0;
                    end
                end
                START: if (tick) begin
                    cnt_d   = '0;
                    state_d = sample ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                PAR: if (tick) begin
                    cnt_d   = '0;
                    pacc_d  = (PARITY == 1) ? (^{shift_q, sample}) : ~(^{shift_q, sample});
                    state_d = STOP;
                end
                STOP: if (tick) begin
                    cnt_d  = '0;
                    facc_d = facc_q | ~sample;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        state_d = DONE;
                        data_d  = shift_q;
                        perr_d  = pacc_q;
                        ferr_d  = facc_q | ~sample;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                DONE: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rx_valid = (state_q == DONE);
        rx_busy  = (state_q != IDLE);
        rx_data  = data_q;
        rx_perr  = perr_q;
        rx_ferr  = ferr_q;
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 8E1, 7O2)
// driven by directed and random frames, checked by a passive monitor.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int CPB = 16;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b1;
    logic [2:0] line = 3'b111;
    logic       mon_en = 1'b0;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [7:0] dat [3];
    logic [2:0] vld, pe, fe, bsy;
    logic [2:0] pv = 3'b000;
    int         DB [3] = '{8, 8, 7};
    int         PM [3] = '{0, 1, 2};
    int         SB [3] = '{1, 1, 2};
    exp_t       sbq [$];
    exp_t       me;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign dat[0] = d0;
    assign dat[1] = d1;
    assign dat[2] = {1'b0, d2};

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_in(line[0]), .rx_data(d0),
        .rx_valid(vld[0]), .rx_perr(pe[0]), .rx_ferr(fe[0]), .rx_busy(bsy[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_in(line[1]), .rx_data(d1),
        .rx_valid(vld[1]), .rx_perr(pe[1]), .rx_ferr(fe[1]), .rx_busy(bsy[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_in(line[2]), .rx_data(d2),
        .rx_valid(vld[2]), .rx_perr(pe[2]), .rx_ferr(fe[2]), .rx_busy(bsy[2]));

    // Monitor: every rx_valid pops one expectation; the cycle after must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (pv[d]) begin
                    checks++;
                    if (bsy[d] !== 1'b0 || vld[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL after_done dut%0d: busy=%b valid=%b, required 0 0", d, bsy[d], vld[d]);
                    end
                end
                if (vld[d] === 1'b1) begin
                    checks++;
                    if (sbq.size() == 0 || sbq[0].dut != d) begin
                        errors++;
                        $display("FAIL unexpected_valid dut%0d: data=%h perr=%b ferr=%b", d, dat[d], pe[d], fe[d]);
                    end else begin
                        me = sbq.pop_front();
                        if (dat[d] !== me.data || pe[d] !== me.perr || fe[d] !== me.ferr) begin
                            errors++;
                            $display("FAIL frame dut%0d: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                                     d, dat[d], pe[d], fe[d], me.data, me.perr, me.ferr);
                        end
                    end
                end
            end
            pv = vld;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic idle(input int d, input int n);
        line[d] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on line d; the line is left at the last bit driven.
    task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                              input logic [1:0] stops, input int glitch,
                              input int stop_after, input bit push);
        logic [15:0] fb;
        int          n;
        int          ones;
        exp_t        e;
        fb = '1;
        n  = 0;
        fb[n] = 1'b0;
        n++;
        for (int i = 0; i < DB[d]; i++) begin
            fb[n] = data[i];
            n++;
        end
        if (PM[d] != 0) begin
            fb[n] = pbit;
            n++;
        end
        for (int s = 0; s < SB[d]; s++) begin
            fb[n] = stops[s];
            n++;
        end
        if (push) begin
            e.dut  = d;
            e.data = data & 8'((1 << DB[d]) - 1);
            ones   = $countones(e.data) + int'(pbit);
            e.perr = (PM[d] == 0) ? 1'b0 : (PM[d] == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
            e.ferr = (SB[d] == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
            sbq.push_back(e);
        end
        for (int c = 0; c < n * CPB; c++) begin
            if (stop_after >= 0 && c >= stop_after) break;
            line[d] = fb[c / CPB] ^ (c == glitch);
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       pb;
        logic [1:0] st;
        logic [7:0] gl_exp;
        exp_t       e;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_data", dat[d], 8'h00);
            check("reset_flags", {4'b0, vld[d], pe[d], fe[d], bsy[d]}, 8'h00);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(0, 8'hA5, 1'b0, 2'b11, -1, -1, 1'b1);
        idle(0, 2 * CPB);
        send_frame(1, 8'h03, 1'b1, 2'b11, -1, -1, 1'b1);
        idle(1, 2 * CPB);
        send_frame(1, 8'h03, 1'b0, 2'b11, -1, -1, 1'b1);
        idle(1, 2 * CPB);

        // break: bad stop bit, then line held low
        send_frame(0, 8'h55, 1'b0, 2'b00, -1, -1, 1'b1);
        repeat (40 * CPB) @(negedge clk);
        check("break_busy", {7'b0, bsy[0]}, 8'h00);
        idle(0, 4 * CPB);
        send_frame(0, 8'h12, 1'b0, 2'b11, -1, -1, 1'b1);
        idle(0, 2 * CPB);

        // short low pulse on an idle line
        line[0] = 1'b0;
        repeat (4) @(negedge clk);
        line[0] = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", {7'b0, bsy[0]}, 8'h01);
        repeat (6) @(negedge clk);
        check("glitch_busy_lo", {7'b0, bsy[0]}, 8'h00);
        idle(0, 2 * CPB);

        // abort by rx_en and by rst during data bit 3
        send_frame(0, 8'h3C, 1'b0, 2'b11, -1, -1, 1'b1);
        idle(0, 2 * CPB);
        send_frame(0, 8'h7E, 1'b0, 2'b11, -1, 72, 1'b0);
        check("en_busy_before", {7'b0, bsy[0]}, 8'h01);
        rx_en = 1'b0;
        @(negedge clk);
        check("en_busy_after", {7'b0, bsy[0]}, 8'h00);
        check("en_data_hold", dat[0], 8'h3C);
        line[0] = 1'b1;
        @(negedge clk);
        rx_en = 1'b1;
        idle(0, 3 * CPB);
        check("en_data_hold2", dat[0], 8'h3C);
        send_frame(0, 8'h7E, 1'b0, 2'b11, -1, 72, 1'b0);
        check("rst_busy_before", {7'b0, bsy[0]}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_after", {7'b0, bsy[0]}, 8'h00);
        check("rst_data", dat[0], 8'h00);
        rst = 1'b0;
        idle(0, 3 * CPB);

        // one-cycle high spike at the bit-0 centre
`ifdef UART_RX_MAJORITY_EN
        gl_exp = 8'h00;
`else
        gl_exp = 8'h01;
`endif
        e.dut = 0;
        e.data = gl_exp;
        e.perr = 1'b0;
        e.ferr = 1'b0;
        sbq.push_back(e);
        send_frame(0, 8'h00, 1'b0, 2'b11, CPB + CPB / 2, -1, 1'b0);
        idle(0, 2 * CPB);

        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 20; k++) begin
                rd = 8'($urandom);
                rd = rd & 8'((1 << DB[d]) - 1);
                pb = (PM[d] == 1) ? ^rd : ~(^rd);
                if ($urandom_range(0, 3) == 0) pb = ~pb;
                st[0] = ($urandom_range(0, 4) != 0);
                st[1] = ($urandom_range(0, 4) != 0);
                send_frame(d, rd, pb, st, -1, -1, 1'b1);
                idle(d, int'($urandom_range(1, CPB)));
            end
            idle(d, 2 * CPB);
        end

        idle(0, 4 * CPB);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_valid: %0d frames outstanding, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clk cycles per bit period (50 MHz / 9600 baud); legal range >= 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal values 5 to 8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-007 SHALL have port rx_en  input  1  receive enable, high = run.
REQ-008 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data  output  DATA_BITS  last received data, LSB first on the line.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse, frame complete.
REQ-011 SHALL have port rx_perr  output  1  parity error, meaningful only while rx_valid is high.
REQ-012 SHALL have port rx_ferr  output  1  framing error, meaningful only while rx_valid is high.
REQ-013 SHALL have port rx_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL pass rx_in through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-015 SHALL use internal bit timing: a counter of width clog2(CLKS_PER_BIT), with no external baud module.
REQ-016 SHALL use FSM states IDLE, START, DATA, PAR, STOP, DONE.
REQ-017 IDLE -> START SHALL occur on a 1->0 transition of rs while rx_en=1 (cycle t0); a line already low SHALL NOT trigger a transition.
REQ-018 START: SHALL sample at t0+CLKS_PER_BIT/2 (integer division); sample 0 -> DATA, sample 1 -> IDLE as a glitch, with no rx_valid.
REQ-019 Subsequent samples SHALL occur every CLKS_PER_BIT cycles after the start sample.
REQ-020 DATA: SHALL take DATA_BITS samples, shifted LSB first; PAR is entered if PARITY!=0, else STOP.
REQ-021 PAR: rx_perr SHALL be set when XOR(data, parity bit) is 1 for even parity, or 0 for odd parity; rx_perr=0 when PARITY=0.
REQ-022 STOP: SHALL take STOP_BITS samples; rx_ferr=1 if any stop sample is 0; every stop bit SHALL be sampled even after an error.
REQ-023 DONE SHALL last one cycle, entered the cycle after the last stop sample; rx_valid=1, and rx_data, rx_perr, rx_ferr SHALL update at that same edge.
REQ-024 DONE -> IDLE SHALL be unconditional; a start edge SHALL be accepted from the next cycle.
REQ-025 rx_data SHALL hold its value between frames; rx_perr and rx_ferr SHALL hold their last value but are qualified by rx_valid.
REQ-026 rx_en=0 in any state SHALL force IDLE at the next edge, discarding the partial frame: no rx_valid, rx_data unchanged.
REQ-027 A line held low after a framing error (break) SHALL NOT produce further frames until rs returns high and falls again.

Reset
REQ-028 rst=1 SHALL force, at the next clk edge: FSM IDLE, counters 0, rx_data 0, rx_valid 0, rx_perr 0, rx_ferr 0, rx_busy 0, synchronizer flops 1.
REQ-029 rst mid-frame SHALL abort the frame with no rx_valid; rst SHALL take priority over rx_en.

Configuration
REQ-030 Macro UART_RX_MAJORITY_EN defined: each sample point (start, data, parity, stop) SHALL be the 2-of-3 majority of rs at mid-1, mid and mid+1.
REQ-031 Macro UART_RX_MAJORITY_EN undefined: each sample SHALL be the single rs value at mid; bit timing and rx_valid latency SHALL be identical in both builds.

Verification (CLKS_PER_BIT=16)
REQ-032 8N1, byte 0xA5 -> exactly one rx_valid pulse, rx_data=0xA5, rx_perr=0, rx_ferr=0, rx_busy low the cycle after.
REQ-033 PARITY=1, byte 0x03 sent with parity bit 1 -> rx_valid, rx_data=0x03, rx_perr=1; the same byte with parity bit 0 -> rx_perr=0.
REQ-034 Byte 0x55 with stop bit 0, line then held low for 40 bit times -> one rx_valid with rx_ferr=1 and no further rx_valid; line released high, then byte 0x12 -> rx_data=0x12, rx_ferr=0.
REQ-035 Idle line pulsed low for 4 cycles -> no rx_valid; rx_busy returns to 0 at or before t0+9.
REQ-036 rx_en dropped at data bit 3 of 0x7E (likewise rst) -> rx_busy 0 on the next edge, no rx_valid, rx_data retains its previous value.
REQ-037 Byte 0x00 with a 1-cycle high glitch at the bit-0 mid sample -> with UART_RX_MAJORITY_EN rx_data=0x00; without it rx_data=0x01.
